// File: rtl/seq_tiled_array_mult.sv
// Iterative unsigned WIDTH x WIDTH multiplier reusing one BLK x BLK array-multiplier tile per cycle.
// Optional build macro: SEQ_TILED_ARRAY_MULT_ZERO_SKIP_EN (zero-operand and zero-row skipping).
`timescale 1ns/1ps
module seq_tiled_array_mult #(
  parameter int WIDTH = 16,
  parameter int BLK   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int N  = WIDTH / BLK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % BLK) != 0 || BLK < 2) begin : g_param_check
    $error("seq_tiled_array_mult: WIDTH must be a multiple of BLK and BLK must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d, p_q, p_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [BLK-1:0]   a_dig, b_dig;
  logic [2*BLK-1:0] tile_p;
  logic [PW-1:0]    term, sum, p_fin;
  logic             finish;

  assign a_dig = a_q[BLK*i_q +: BLK];
  assign b_dig = b_q[BLK*j_q +: BLK];

  // Tile: row r adds the partial-product row a_dig & b_dig[r] to the upper bits of row r-1.
  // Bit 0 of each row's sum is a finished product bit; the last row supplies the top BLK+1 bits.
  for (genvar r = 0; r < BLK; r++) begin : g_row
    logic [BLK:0]   part;
    logic [BLK-1:0] pp;
    assign pp = a_dig & {BLK{b_dig[r]}};
    if (r == 0) begin : g_first
      assign part = {1'b0, pp};
    end else begin : g_add
      logic cy;
      always_comb begin
        cy   = 1'b0;
        part = '0;
        for (int k = 0; k < BLK; k++) begin
          part[k] = g_row[r-1].part[k+1] ^ pp[k] ^ cy;
          cy      = (g_row[r-1].part[k+1] & pp[k]) | (cy & (g_row[r-1].part[k+1] ^ pp[k]));
        end
        part[BLK] = cy;
      end
    end
    if (r < BLK - 1) begin : g_lo
      assign tile_p[r] = part[0];
    end else begin : g_hi
      assign tile_p[2*BLK-1:BLK-1] = part;
    end
  end

  assign term = PW'(tile_p) << (BLK * (int'(i_q) + int'(j_q)));
  assign sum  = acc_q + term;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    p_d         = p_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    finish      = 1'b0;
    p_fin       = sum;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      BUSY: begin
`ifdef SEQ_TILED_ARRAY_MULT_ZERO_SKIP_EN
        if (a_q == '0 || b_q == '0) begin
          finish = 1'b1;
          p_fin  = '0;
        end else if (i_q == '0 && b_dig == '0) begin
          // An all-zero multiplier digit contributes nothing to its whole row.
          if (j_q == LAST) begin
            finish = 1'b1;
            p_fin  = acc_q;
          end else begin
            j_d = j_q + CW'(1);
          end
        end else
`endif
        begin
          acc_d = sum;
          if (i_q == LAST) begin
            i_d = '0;
            if (j_q == LAST) finish = 1'b1;
            else             j_d = j_q + CW'(1);
          end else begin
            i_d = i_q + CW'(1);
          end
        end
        if (finish) begin
          state_d     = DONE;
          p_d         = p_fin;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_seq_tiled_array_mult.sv
// Scoreboard bench for seq_tiled_array_mult: a 16/8 instance and a 32/8 instance, expected
// products and latencies queued at issue time and checked by per-instance monitors.
`timescale 1ns/1ps
module tb_seq_tiled_array_mult;
`ifdef SEQ_TILED_ARRAY_MULT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, out_ready;
  logic        in_valid, in_ready, out_valid, busy;
  logic [15:0] a, b;
  logic [31:0] p;
  logic        in_valid_w, in_ready_w, out_valid_w, busy_w;
  logic [31:0] a_w, b_w;
  logic [63:0] p_w;

  seq_tiled_array_mult #(.WIDTH(16), .BLK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

  seq_tiled_array_mult #(.WIDTH(32), .BLK(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .p(p_w), .busy(busy_w));

  typedef struct {
    logic [63:0] p;
    int          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] x, input logic [63:0] y, input int n);
    int zeros = 0;
    for (int j = 0; j < n; j++) if (((y >> (8 * j)) & 64'hFF) == 64'h0) zeros++;
    if (!ZS) return n * n;
    if (x == 64'h0 || y == 64'h0) return 1;
    return (n - zeros) * n + zeros;
  endfunction

  // Monitor for the 16-bit instance
  int   acc16 = 0;
  bit   ovp16 = 1'b0, low16 = 1'b0;
  exp_t e16;
  always @(negedge clk) begin
    if (!rst_n) begin
      ovp16 = 1'b0;
      low16 = 1'b0;
    end else begin
      if (low16) begin
        check("ov16_single_cycle", out_valid, 0);
        low16 = 1'b0;
      end
      if (in_valid && in_ready) acc16 = cyc + 1;
      if (out_valid && !ovp16) begin
        if (q16.size() == 0) check("ov16_unexpected", out_valid, 0);
        else                 check("lat16", cyc - acc16, q16[0].lat);
      end
      if (out_valid && out_ready && q16.size() != 0) begin
        e16 = q16.pop_front();
        check("p16", p, e16.p);
        low16 = 1'b1;
      end
      ovp16 = out_valid;
    end
  end

  // Monitor for the 32-bit instance
  int   acc32 = 0;
  bit   ovp32 = 1'b0, low32 = 1'b0;
  exp_t e32;
  always @(negedge clk) begin
    if (!rst_n) begin
      ovp32 = 1'b0;
      low32 = 1'b0;
    end else begin
      if (low32) begin
        check("ov32_single_cycle", out_valid_w, 0);
        low32 = 1'b0;
      end
      if (in_valid_w && in_ready_w) acc32 = cyc + 1;
      if (out_valid_w && !ovp32) begin
        if (q32.size() == 0) check("ov32_unexpected", out_valid_w, 0);
        else                 check("lat32", cyc - acc32, q32[0].lat);
      end
      if (out_valid_w && out_ready && q32.size() != 0) begin
        e32 = q32.pop_front();
        check("p32", p_w, e32.p);
        low32 = 1'b1;
      end
      ovp32 = out_valid_w;
    end
  end

  task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic [63:0] e,
                         input int lat, input bit push);
    int n = 0;
    if (push) q16.push_back('{e, lat});
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("issue16_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e,
                         input int lat);
    int n = 0;
    q32.push_back('{e, lat});
    a_w = x; b_w = y; in_valid_w = 1'b1;
    @(negedge clk);
    while (!in_ready_w && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("issue32_timeout", in_ready_w, 1);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
  endtask

  task automatic drain16();
    int n = 0;
    while ((q16.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("drain16_timeout", q16.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain32();
    int n = 0;
    while ((q32.size() != 0 || !in_ready_w) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("drain32_timeout", q32.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] rx, ry;
  logic [31:0] rxw, ryw;
  int          wn;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0;
    in_valid_w = 1'b0; a_w = '0; b_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p, 0);
    check("rst_in_ready_w", in_ready_w, 1);
    check("rst_p_w", p_w, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue16(16'hFFFF, 16'hFFFF, 64'hFFFE0001, 4, 1'b1);
    check("busy_after_accept", busy, 1);
    drain16();

    // Backpressure: DONE must hold steady while out_ready is low.
    out_ready = 1'b0;
    issue16(16'h1234, 16'h5678, 64'h06260060, 4, 1'b1);
    wn = 0;
    while (!out_valid && wn < 50) begin @(negedge clk); wn++; end
    if (wn >= 50) check("bp_wait_timeout", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_p", p, 64'h06260060);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_hs", in_ready, 1);
    @(posedge clk); #1;

    // in_valid pulse during BUSY, with operand buses changing, must be ignored.
    issue16(16'h00FF, 16'h0100, 64'h0000FF00, ZS ? 3 : 4, 1'b1);
    a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain16();
    repeat (6) @(negedge clk);
    check("no_second_ov", out_valid, 0);
    check("p_held", p, 64'h0000FF00);
    @(posedge clk); #1;

    // Reset in the second BUSY cycle aborts the operation at once.
    issue16(16'h0003, 16'h0005, 64'h0, 0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_p", p, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue16(16'h0010, 16'h0010, 64'h00000100, ZS ? 3 : 4, 1'b1);
    drain16();

    issue16(16'h0000, 16'hABCD, 64'h0, ZS ? 1 : 4, 1'b1);
    drain16();
    issue16(16'hABCD, 16'h0000, 64'h0, ZS ? 1 : 4, 1'b1);
    drain16();

    // Back-to-back random operands, some with a zeroed multiplier digit.
    for (int k = 0; k < 200; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (k % 5 == 0) ry[7:0] = 8'h00;
      if (k % 7 == 0) ry[15:8] = 8'h00;
      issue16(rx, ry, 64'(rx) * 64'(ry), exp_lat(64'(rx), 64'(ry), 2), 1'b1);
    end
    drain16();

    issue32(32'hFFFFFFFF, 32'h00000002, 64'h1_FFFF_FFFE, ZS ? 7 : 16);
    drain32();
    for (int k = 0; k < 1000; k++) begin
      rxw = $urandom;
      ryw = $urandom;
      if (k % 9 == 0) ryw[15:8] = 8'h00;
      issue32(rxw, ryw, 64'(rxw) * 64'(ryw), exp_lat(64'(rxw), 64'(ryw), 4));
    end
    drain32();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
